// File: rtl/serial_frame_transmitter.sv
// Serial frame transmitter: idle-high line, start bit, port, length, payload, stop bit.
// Sends every field MSB-first and moves one bit on each clkEn pulse.
module serial_frame_transmitter #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              Start,
    input  logic [PORT_W-1:0] PortIn,
    input  logic [LEN_W-1:0]  LenIn,
    input  logic [DATA_W-1:0] DataIn,
    output logic              SerOut,
    output logic              Done,
    output logic              FrameDone
);
    // state | meaning
    // IDLE  | line high, ready for a frame
    // START | start bit (0)
    // PORT  | port address bits
    // LEN   | length field bits
    // DATA  | payload bits, L of them
    // STOP  | stop bit (1)
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;

    state_t            state;
    logic [PORT_W-1:0] port_sh;
    logic [LEN_W-1:0]  len_sh;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_sh;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            port_sh   <= '0;
            len_sh    <= '0;
            len_q     <= '0;
            data_sh   <= '0;
            cnt       <= '0;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            if (clkEn) begin
                unique case (state)
                    IDLE: begin
                        if (Start) begin
                            port_sh <= PortIn;
                            len_sh  <= LenIn;
                            len_q   <= LenIn;
                            // left-align the payload so DataIn[L-1] is the first bit out
                            data_sh <= DataIn << (LEN_W'(DATA_W) - LenIn);
                            state   <= START;
                        end
                    end
                    START: begin
                        cnt   <= '0;
                        state <= PORT;
                    end
                    PORT: begin
                        if (cnt == CNT_W'(PORT_W - 1)) begin
                            cnt   <= '0;
                            state <= LEN;
                        end else begin
                            port_sh <= port_sh << 1;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                    LEN: begin
                        if (cnt == CNT_W'(LEN_W - 1)) begin
                            cnt   <= '0;
                            state <= (len_q != '0) ? DATA : STOP;
                        end else begin
                            len_sh <= len_sh << 1;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        // only reached with len_q >= 1, so len_q-1 cannot underflow
                        if (cnt == CNT_W'(len_q - 1'b1)) begin
                            cnt   <= '0;
                            state <= STOP;
                        end else begin
                            data_sh <= data_sh << 1;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        state     <= IDLE;
                        FrameDone <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        SerOut = 1'b1;
        unique case (state)
            IDLE:    SerOut = 1'b1;
            START:   SerOut = 1'b0;
            PORT:    SerOut = port_sh[PORT_W-1];
            LEN:     SerOut = len_sh[LEN_W-1];
            DATA:    SerOut = data_sh[DATA_W-1];
            STOP:    SerOut = 1'b1;
            default: SerOut = 1'b1;
        endcase
    end

    assign Done = (state == IDLE);

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Bench for serial_frame_transmitter: a per-bit queue model of the frame checked every cycle,
// plus literal bit sequences for the directed frames.
module tb_serial_frame_transmitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkEn = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  PortIn = '0;
    logic [3:0]  LenIn = '0;
    logic [14:0] DataIn = '0;
    logic        SerOut, Done, FrameDone;

    int tests = 0;
    int fails = 0;

    serial_frame_transmitter dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .Start(Start),
        .PortIn(PortIn), .LenIn(LenIn), .DataIn(DataIn),
        .SerOut(SerOut), .Done(Done), .FrameDone(FrameDone)
    );

    always #5 clk = ~clk;

    // bit-rate enable: en_div==0 holds it low, otherwise high one cycle in en_div
    int en_div = 0;
    int cyc = 0;
    always @(negedge clk) begin
        cyc++;
        clkEn = (en_div == 0) ? 1'b0 : ((cyc % en_div) == 0);
    end

    // model: the whole frame is a queue of line bits; the head is what is on the line now
    bit mq[$];
    bit m_busy = 1'b0;
    bit m_ser = 1'b1, m_done = 1'b1, m_fd = 1'b0;
    always @(posedge clk) begin
        m_fd = 1'b0;
        if (rst) begin
            mq.delete();
            m_busy = 1'b0;
        end else if (clkEn) begin
            if (m_busy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_busy = 1'b0;
                    m_fd = 1'b1;
                end
            end else if (Start) begin
                mq.push_back(1'b0);
                for (int i = 1; i >= 0; i--) mq.push_back(PortIn[i]);
                for (int i = 3; i >= 0; i--) mq.push_back(LenIn[i]);
                for (int i = int'(LenIn) - 1; i >= 0; i--) mq.push_back(DataIn[i]);
                mq.push_back(1'b1);
                m_busy = 1'b1;
            end
        end
        m_ser  = m_busy ? mq[0] : 1'b1;
        m_done = !m_busy;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    bit chk_en = 1'b0;
    logic en_prev = 1'b0;
    bit seen[$];
    int busy_cyc = 0, idle_per = 0, fd_cnt = 0;

    always @(posedge clk) en_prev <= clkEn;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ser_model", SerOut, m_ser);
            check("done_model", Done, m_done);
            check("framedone_model", FrameDone, m_fd);
            if (FrameDone) fd_cnt++;
            if (!Done) busy_cyc++;
            if (en_prev && !Done) seen.push_back(SerOut);
            if (en_prev && Done) idle_per++;
        end
    end

    task automatic check_seq(string name, logic [63:0] exp, int n);
        logic [63:0] got;
        bit ok;
        got = '0;
        ok = (seen.size() == n);
        foreach (seen[i]) begin
            got = {got[62:0], seen[i]};
            if (i < n && seen[i] !== exp[n-1-i]) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d bits %b, expected %0d bits %b", name, seen.size(), got, n, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(logic v, string name);
        int n = 0;
        while (Done !== v && n < 400) begin
            step();
            n++;
        end
        if (Done !== v) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, Done=%b expected %b", name, Done, v);
        end
    endtask

    task automatic send(logic [1:0] p, logic [3:0] l, logic [14:0] d, string name);
        PortIn = p;
        LenIn  = l;
        DataIn = d;
        Start  = 1'b1;
        wait_done(1'b0, name);
        Start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [22:0] frm6;
    int fd0, n;

    initial begin
        // 1: reset with clkEn low
        rst = 1'b1;
        en_div = 0;
        step();
        check("rst_ser", SerOut, 1);
        check("rst_done", Done, 1);
        check("rst_framedone", FrameDone, 0);
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        en_div = 1;
        step();

        // 2: port 10, L=3, data 101
        seen.delete();
        fd0 = fd_cnt;
        busy_cyc = 0;
        send(2'b10, 4'd3, 15'b101, "t2_accept");
        wait_done(1'b1, "t2_end");
        check_seq("t2_bits", 64'b01000111011, 11);
        check("t2_framedone_count", fd_cnt - fd0, 1);
        check("t2_busy_cycles", busy_cyc, 11);
        check("t2_done_after", Done, 1);

        // 3: L=0 skips payload; junk DataIn must not appear
        seen.delete();
        send(2'b01, 4'd0, 15'h7FFF, "t3_accept");
        wait_done(1'b1, "t3_end");
        check_seq("t3_bits", 64'b00100001, 8);

        // 4: clkEn one cycle in four
        en_div = 4;
        repeat (5) step();
        seen.delete();
        busy_cyc = 0;
        send(2'b00, 4'd2, 15'b10, "t4_accept");
        wait_done(1'b1, "t4_end");
        check_seq("t4_bits", 64'b0000010101, 10);
        check("t4_busy_cycles", busy_cyc, 40);
        n = 0;
        while (!clkEn && n < 8) begin
            step();
            n++;
        end
        step();
        PortIn = 2'b11;
        LenIn  = 4'd5;
        Start  = 1'b1;
        repeat (3) begin
            step();
            check("t4_start_ignored", Done, 1);
        end
        Start = 1'b0;
        repeat (4) begin
            step();
            check("t4_still_idle", Done, 1);
        end

        // 5: reset mid-payload, then a short frame
        en_div = 1;
        step();
        send(2'b11, 4'd15, 15'h7FFF, "t5a_accept");
        repeat (10) step();
        check("t5_in_frame", Done, 0);
        rst = 1'b1;
        step();
        check("t5_abort_ser", SerOut, 1);
        check("t5_abort_done", Done, 1);
        Start = 1'b1;
        step();
        check("t5_rst_beats_start", Done, 1);
        rst = 1'b0;
        Start = 1'b0;
        step();
        seen.delete();
        send(2'b11, 4'd1, 15'd1, "t5b_accept");
        wait_done(1'b1, "t5b_end");
        check_seq("t5_bits", 64'b011000111, 9);

        // 6: Start held for two full-length frames
        step();
        seen.delete();
        PortIn = 2'b10;
        LenIn  = 4'd15;
        DataIn = 15'h5555;
        Start  = 1'b1;
        wait_done(1'b0, "t6_accept1");
        idle_per = 0;
        wait_done(1'b1, "t6_end1");
        wait_done(1'b0, "t6_accept2");
        check("t6_idle_gap", idle_per, 1);
        Start = 1'b0;
        wait_done(1'b1, "t6_end2");
        frm6 = {1'b0, 2'b10, 4'hF, 15'h5555, 1'b1};
        check_seq("t6_bits", {18'b0, frm6, frm6}, 46);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_frame_transmitter.md
Name: serial_frame_transmitter

Overview:
Serial transmitter that builds the frame our serial receiver controller decodes: idle-high line, a 0 start bit, 2-bit port address, 4-bit data length L, L data bits, then one stop bit of 1. All fields are sent MSB-first. It loads a frame on a Start/Done handshake and advances one bit per clkEn pulse, so it shares its bit-rate enable with the receiver side.

Parameters:
PORT_W, 2, port address field width in bits
LEN_W, 4, length field width in bits
DATA_W, 15, data register width; must equal 2**LEN_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
clkEn  input  1  bit-rate enable; the FSM advances only on edges where it is 1
Start  input  1  frame request; held high until accepted
PortIn  input  PORT_W  destination port address
LenIn  input  LEN_W  number of data bits L (0..15)
DataIn  input  DATA_W  payload; bits DataIn[L-1:0] are sent, DataIn[L-1] first
SerOut  output  1  serial line
Done  output  1  high in IDLE (ready for a new frame)
FrameDone  output  1  one-clk pulse on the edge that leaves STOP

Behaviour:
- Reset: rst has priority over clkEn and is sampled on clk edges only. It forces IDLE; SerOut=1, Done=1, FrameDone=0, and clears the shift/length registers and bit counter.
- States: IDLE, START, PORT, LEN, DATA, STOP.
- State register updates only on edges with clkEn=1, so each state or bit holds for one full bit period.
- Outputs are Moore decodes of the current state and registers:
  - IDLE: SerOut=1, Done=1.
  - START: SerOut=0.
  - PORT, LEN, DATA: SerOut = MSB of the active field register.
  - STOP: SerOut=1.
  - Done=0 in every state except IDLE.
- Acceptance edge: state==IDLE && clkEn && Start.
  - On that edge, capture PortIn, LenIn and DataIn left-aligned so DataIn[L-1] sits at the MSB; go to START.
  - Inputs are ignored at all other times.
  - Start pulses that do not coincide with clkEn in IDLE are not accepted.
- Transitions (all on clkEn edges):
  - START -> PORT, bit counter cleared.
  - PORT: shift one bit per clkEn; after PORT_W bits -> LEN.
  - LEN: shift one bit per clkEn; after LEN_W bits -> DATA if L!=0, else -> STOP.
  - DATA: shift one bit per clkEn; after L bits -> STOP.
  - STOP -> IDLE; FrameDone=1 for the clk cycle following that edge.
- Frame length: 1+PORT_W+LEN_W+L+1 bit periods (8..23 with defaults).
- Back-to-back: IDLE always lasts at least one bit period between frames. If Start is held high, the next START begins exactly one bit period after STOP ends.
- Bit counter: 4 bits, reset to 0 on each field entry. Compare width must cover DATA_W.
- L=0 skips DATA entirely; no wrap or underflow of the counter.
- Reset mid-frame: abort immediately. SerOut=1 and Done=1 from the next cycle; the partial frame is not resumed.
- Simultaneous rst and Start: reset wins; the frame is not accepted.

Test Plan:
1. Assert rst with clkEn=0 for 2 cycles -> SerOut=1, Done=1, FrameDone=0 after the first clk edge.
2. clkEn=1 every cycle; PortIn=2'b10, LenIn=4'd3, DataIn=15'b101 -> SerOut per bit 0,1,0,0,0,1,1,1,0,1,1 (11 bits). Done=0 throughout; FrameDone pulses once; Done=1 afterwards.
3. PortIn=2'b01, LenIn=0 -> SerOut 0,0,1,0,0,0,0,1 (8 bits); no DATA state visited.
4. clkEn high 1 cycle in 4 -> every bit held exactly 4 clks. A Start pulse lasting only non-clkEn cycles is never accepted; Done stays 1.
5. rst asserted mid-DATA of a LenIn=15 frame -> next cycle SerOut=1, Done=1. A following frame with PortIn=2'b11, LenIn=1, DataIn=1 emits 0,1,1,0,0,0,1,1,1.
6. Start held high, two frames of LenIn=15, DataIn=15'h5555 -> correct alternating payload 1,0,1,...; exactly one idle-high bit between stop bit and next start bit.
